// File: rtl/div_unit.sv
// div_unit: multi-cycle integer divider for the RISC-V M-extension
// DIV, DIVU, REM and REMU operations.
//
// Restoring shift-subtract, one quotient bit per clock. Divide-by-zero
// and signed overflow finish in one clock without iterating.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          launch request, sampled only while idle
//   abort          synchronous cancel of an in-flight operation
//   operand_a/b    dividend / divisor
//   div_sel_*      operation select; priority div > divu > rem > remu
//   busy           high while not idle
//   done           one-cycle pulse, result valid in that cycle
//   result         quotient or remainder (registered, held until next op)
//   div_zero       set with done when the divisor was zero
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             div_sel_div,
   input  logic             div_sel_divu,
   input  logic             div_sel_rem,
   input  logic             div_sel_remu,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;        // running remainder (always < divisor)
   logic [WIDTH-1:0] quo_q, quo_d;        // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_rem_q, is_rem_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             div_zero_q, div_zero_d;

   logic             accept_s;
   logic             op_signed_s;
   logic             op_rem_s;
   logic             b_zero_s;
   logic             overflow_s;
   logic             last_iter_s;
   logic [WIDTH:0]   partial_s;           // shifted partial remainder
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] rem_nxt_s;
   logic [WIDTH-1:0] quo_nxt_s;
   logic [WIDTH-1:0] final_s;

   // Launch decode: abort in IDLE suppresses a same-cycle start.
   always_comb begin
      accept_s    = (state_q == S_IDLE) && start && !abort &&
                    (div_sel_div || div_sel_divu || div_sel_rem || div_sel_remu);
      op_signed_s = div_sel_div || (!div_sel_divu && div_sel_rem);
      op_rem_s    = !div_sel_div && !div_sel_divu;
      b_zero_s    = (operand_b == {WIDTH{1'b0}});
      overflow_s  = op_signed_s && (operand_a == MOST_NEG) && (operand_b == {WIDTH{1'b1}});
      last_iter_s = (cnt_q == CW'(WIDTH-1));
   end

   // One restoring step plus the sign fix-up of its outcome.
   always_comb begin
      partial_s = {rem_q, quo_q[WIDTH-1]};
      trial_s   = partial_s - {1'b0, dvs_q};
      if (!trial_s[WIDTH]) begin
         rem_nxt_s = trial_s[WIDTH-1:0];
         quo_nxt_s = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt_s = partial_s[WIDTH-1:0];
         quo_nxt_s = {quo_q[WIDTH-2:0], 1'b0};
      end
      // Negating zero gives zero, so a zero remainder keeps its sign.
      if (is_rem_q) begin
         final_s = r_neg_q ? -rem_nxt_s : rem_nxt_s;
      end else begin
         final_s = q_neg_q ? -quo_nxt_s : quo_nxt_s;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = (b_zero_s || overflow_s) ? S_DONE : S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_iter_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: operand capture, iteration and result update.
   always_comb begin
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      is_rem_d   = is_rem_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               div_zero_d = 1'b0;
               is_rem_d   = op_rem_s;
               if (b_zero_s) begin
                  div_zero_d = 1'b1;
                  result_d   = op_rem_s ? operand_a : {WIDTH{1'b1}};
               end else if (overflow_s) begin
                  result_d = op_rem_s ? {WIDTH{1'b0}} : operand_a;
               end else begin
                  rem_d   = {WIDTH{1'b0}};
                  quo_d   = (op_signed_s && operand_a[WIDTH-1]) ? -operand_a : operand_a;
                  dvs_d   = (op_signed_s && operand_b[WIDTH-1]) ? -operand_b : operand_b;
                  cnt_d   = {CW{1'b0}};
                  q_neg_d = op_signed_s && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                  r_neg_d = op_signed_s && operand_a[WIDTH-1];
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_CALC: begin
            if (abort) begin
               cnt_d = {CW{1'b0}};
            end else begin
               rem_d = rem_nxt_s;
               quo_d = quo_nxt_s;
               cnt_d = cnt_q + CW'(1);
               if (last_iter_s) begin
                  result_d = final_s;
               end else begin
                  result_d = result_q;
               end
            end
         end
         S_DONE:  cnt_d = {CW{1'b0}};
         default: cnt_d = {CW{1'b0}};
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q      <= {WIDTH{1'b0}};
         quo_q      <= {WIDTH{1'b0}};
         dvs_q      <= {WIDTH{1'b0}};
         cnt_q      <= {CW{1'b0}};
         is_rem_q   <= 1'b0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         result_q   <= {WIDTH{1'b0}};
         div_zero_q <= 1'b0;
      end else begin
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         is_rem_q   <= is_rem_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Outputs decode only registered state.
   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      result   = result_q;
      div_zero = div_zero_q;
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] operand_a = 32'd0;
   logic [31:0] operand_b = 32'd0;
   logic        div_sel_div = 1'b0;
   logic        div_sel_divu = 1'b0;
   logic        div_sel_rem = 1'b0;
   logic        div_sel_remu = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        div_zero;

   int tests = 0;
   int fails = 0;
   int lat;
   int busy_n;
   logic seen_done;

   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REM  = 4'b0010;
   localparam logic [3:0] OP_REMU = 4'b0001;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .operand_a(operand_a), .operand_b(operand_b),
      .div_sel_div(div_sel_div), .div_sel_divu(div_sel_divu),
      .div_sel_rem(div_sel_rem), .div_sel_remu(div_sel_remu),
      .busy(busy), .done(done), .result(result), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_sel(input logic [3:0] sel);
      {div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu} = sel;
   endtask

   // Drive a start for one cycle; returns at the negedge of cycle 1.
   task automatic launch(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; set_sel(sel); operand_a = a; operand_b = b;
      @(negedge clk);
      start = 1'b0; set_sel(4'b0000);
      operand_a = $urandom; operand_b = $urandom;
   endtask

   // Wait (bounded) for done; lat is the cycle number in which done is seen.
   task automatic wait_done(input int first, output int l, output int bn);
      l = first; bn = 0;
      while (!done && l < 100) begin
         if (busy) bn++;
         @(negedge clk);
         l++;
      end
      if (busy) bn++;
   endtask

   task automatic run(input string tag, input logic [3:0] sel, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                      input logic exp_dz);
      launch(sel, a, b);
      wait_done(1, lat, busy_n);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " result"}, result, exp_res);
      chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
      @(negedge clk);
      chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
      chk({tag, " hold"}, result, exp_res);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst div_zero", {31'd0, div_zero}, 32'd0);
      rst = 1'b0;

      // DIVU 100/7 with busy duration
      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done(1, lat, busy_n);
      chk("divu latency", 32'(lat), 32'd33);
      chk("divu busy cycles", 32'(busy_n), 32'd33);
      chk("divu result", result, 32'd14);
      @(negedge clk);
      chk("divu done one cycle", {31'd0, done}, 32'd0);
      chk("divu busy low", {31'd0, busy}, 32'd0);

      run("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
      run("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
      run("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
      run("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
      run("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 1'b0);
      run("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
      run("remu 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b1);
      run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
      run("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
      // All selects set: DIV wins, -7/2 signed
      run("priority", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);

      // start while busy is ignored
      launch(OP_DIVU, 32'd100, 32'd7);
      repeat (8) @(negedge clk);
      start = 1'b1; set_sel(OP_DIVU); operand_a = 32'd200; operand_b = 32'd1;
      @(negedge clk);
      start = 1'b0; set_sel(4'b0000);
      wait_done(10, lat, busy_n);
      chk("busy start latency", 32'(lat), 32'd33);
      chk("busy start result", result, 32'd14);
      @(negedge clk);
      chk("busy start no relaunch", {31'd0, busy}, 32'd0);

      // start with no select bit
      @(negedge clk);
      start = 1'b1; operand_a = 32'd9; operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("nosel busy", {31'd0, busy}, 32'd0);

      // abort in IDLE beats start
      start = 1'b1; abort = 1'b1; set_sel(OP_DIVU);
      @(negedge clk);
      start = 1'b0; abort = 1'b0; set_sel(4'b0000);
      chk("idle abort busy", {31'd0, busy}, 32'd0);

      // rst mid-CALC
      launch(OP_DIVU, 32'd100, 32'd7);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid rst busy", {31'd0, busy}, 32'd0);
      chk("mid rst done", {31'd0, done}, 32'd0);
      chk("mid rst result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // abort at cycle 20
      launch(OP_DIVU, 32'd100, 32'd7);
      repeat (19) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort busy", {31'd0, busy}, 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen_done = 1'b1;
         @(negedge clk);
      end
      chk("abort no done", {31'd0, seen_done}, 32'd0);
      chk("abort result kept", result, 32'd0);

      run("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

      // abort on the CALC->DONE edge suppresses done and result update
      launch(OP_DIVU, 32'd100, 32'd7);
      repeat (31) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("late abort done", {31'd0, done}, 32'd0);
      chk("late abort busy", {31'd0, busy}, 32'd0);
      chk("late abort result", result, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
